// File: rtl/battle_pkg.sv
// Shared phase encodings, board-size default and a constant clog2 helper
// used by the Keyboard Battleship phase controller and its popcount.
package battle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_P1_PLACE  = 3'd1,
        ST_P2_PLACE  = 3'd2,
        ST_P1_FIRE   = 3'd3,
        ST_P1_RESULT = 3'd4,
        ST_P2_FIRE   = 3'd5,
        ST_P2_RESULT = 3'd6,
        ST_GAMEOVER  = 3'd7
    } state_t;

    localparam int GRID_CELLS_DEFAULT = 36;

    // Ceiling log2 for elaboration-time widths; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ship_popcount.sv
// Combinational population count of a placement mask, one bit per board cell.
module ship_popcount
    import battle_pkg::*;
#(
    parameter int GRID_CELLS = GRID_CELLS_DEFAULT,
    parameter int CNT_W      = clog2(GRID_CELLS + 1)
) (
    input  logic [GRID_CELLS-1:0] mask_i,
    output logic [CNT_W-1:0]      count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < GRID_CELLS; i++) begin
            count_o = count_o + CNT_W'(mask_i[i]);
        end
    end

endmodule

// File: rtl/battle_sequencer.sv
// Game-phase controller: placement, alternating fire turns with a timed
// result hold, and game-over, all driven from one registered state machine.
module battle_sequencer
    import battle_pkg::*;
#(
    parameter int GRID_CELLS  = GRID_CELLS_DEFAULT,
    parameter int NUM_SHIPS   = 5,
    parameter int HOLD_CYCLES = 100000000,
    parameter int EXTRA_TURN  = 0
) (
    input  logic                  clk,
    input  logic                  CPU_RESETN,
    input  logic                  start,
    input  logic                  enter,
    input  logic [GRID_CELLS-1:0] p1ships,
    input  logic [GRID_CELLS-1:0] p2ships,
    input  logic [GRID_CELLS-1:0] newp1ships,
    input  logic [GRID_CELLS-1:0] newp2ships,
    input  logic                  p1hit,
    input  logic                  p1miss,
    input  logic                  p2hit,
    input  logic                  p2miss,
    output logic [2:0]            state,
    output logic                  p1place,
    output logic                  p2place,
    output logic                  p1fire,
    output logic                  p2fire,
    output logic                  taking_turns,
    output logic                  place_err,
    output logic                  last_hit,
    output logic                  p1wins,
    output logic                  p2wins,
    output logic [7:0]            p1_shots,
    output logic [7:0]            p2_shots
);

    localparam int                CNT_W        = clog2(GRID_CELLS + 1);
    localparam int                HOLD_W       = clog2(HOLD_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  SHIPS_NEEDED = CNT_W'(NUM_SHIPS);
    localparam logic [HOLD_W-1:0] HOLD_LOAD    = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [7:0]        SHOT_MAX     = 8'hFF;

    state_t            state_q;
    logic              enter_q;
    logic [HOLD_W-1:0] holdCnt_q;
    logic              p1place_q;
    logic              p2place_q;
    logic              p1fire_q;
    logic              p2fire_q;
    logic              takingTurns_q;
    logic              placeErr_q;
    logic              lastHit_q;
    logic              p1wins_q;
    logic              p2wins_q;
    logic [7:0]        p1Shots_q;
    logic [7:0]        p2Shots_q;

    logic [CNT_W-1:0]  p1Count;
    logic [CNT_W-1:0]  p2Count;
    logic              enterRise;
    logic              p1Shot;
    logic              p2Shot;
    logic [7:0]        p1Shots_d;
    logic [7:0]        p2Shots_d;

    ship_popcount #(.GRID_CELLS(GRID_CELLS), .CNT_W(CNT_W)) u_p1Count (
        .mask_i  (p1ships),
        .count_o (p1Count)
    );

    ship_popcount #(.GRID_CELLS(GRID_CELLS), .CNT_W(CNT_W)) u_p2Count (
        .mask_i  (p2ships),
        .count_o (p2Count)
    );

    assign enterRise = enter & ~enter_q;
    assign p1Shot    = p1hit | p1miss;
    assign p2Shot    = p2hit | p2miss;
    assign p1Shots_d = (p1Shots_q == SHOT_MAX) ? SHOT_MAX : p1Shots_q + 8'd1;
    assign p2Shots_d = (p2Shots_q == SHOT_MAX) ? SHOT_MAX : p2Shots_q + 8'd1;

    // Enables are decoded from the current state register, so they follow
    // the state one cycle later; start dropping outranks every transition.
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q       <= ST_IDLE;
            enter_q       <= 1'b0;
            holdCnt_q     <= '0;
            p1place_q     <= 1'b0;
            p2place_q     <= 1'b0;
            p1fire_q      <= 1'b0;
            p2fire_q      <= 1'b0;
            takingTurns_q <= 1'b0;
            placeErr_q    <= 1'b0;
            lastHit_q     <= 1'b0;
            p1wins_q      <= 1'b0;
            p2wins_q      <= 1'b0;
            p1Shots_q     <= '0;
            p2Shots_q     <= '0;
        end else begin
            enter_q       <= enter;
            placeErr_q    <= 1'b0;
            p1place_q     <= (state_q == ST_P1_PLACE);
            p2place_q     <= (state_q == ST_P2_PLACE);
            p1fire_q      <= (state_q == ST_P1_FIRE);
            p2fire_q      <= (state_q == ST_P2_FIRE);
            takingTurns_q <= state_q inside {ST_P1_FIRE, ST_P1_RESULT,
                                             ST_P2_FIRE, ST_P2_RESULT};

            if (state_q != ST_IDLE && !start) begin
                state_q   <= ST_IDLE;
                holdCnt_q <= '0;
                lastHit_q <= 1'b0;
                p1wins_q  <= 1'b0;
                p2wins_q  <= 1'b0;
                p1Shots_q <= '0;
                p2Shots_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start && enterRise) state_q <= ST_P1_PLACE;
                    end
                    ST_P1_PLACE: begin
                        if (enterRise) begin
                            if (p1Count == SHIPS_NEEDED) state_q <= ST_P2_PLACE;
                            else                         placeErr_q <= 1'b1;
                        end
                    end
                    ST_P2_PLACE: begin
                        if (enterRise) begin
                            if (p2Count == SHIPS_NEEDED) state_q <= ST_P1_FIRE;
                            else                         placeErr_q <= 1'b1;
                        end
                    end
                    ST_P1_FIRE: begin
                        if (p1Shot) begin
                            state_q   <= ST_P1_RESULT;
                            lastHit_q <= p1hit;
                            p1Shots_q <= p1Shots_d;
                            holdCnt_q <= HOLD_LOAD;
                        end
                    end
                    ST_P1_RESULT: begin
                        if (holdCnt_q == '0) begin
                            if (newp2ships == '0) begin
                                state_q  <= ST_GAMEOVER;
                                p1wins_q <= 1'b1;
                            end else if (EXTRA_TURN != 0 && lastHit_q) begin
                                state_q <= ST_P1_FIRE;
                            end else begin
                                state_q <= ST_P2_FIRE;
                            end
                        end else begin
                            holdCnt_q <= holdCnt_q - HOLD_W'(1);
                        end
                    end
                    ST_P2_FIRE: begin
                        if (p2Shot) begin
                            state_q   <= ST_P2_RESULT;
                            lastHit_q <= p2hit;
                            p2Shots_q <= p2Shots_d;
                            holdCnt_q <= HOLD_LOAD;
                        end
                    end
                    ST_P2_RESULT: begin
                        if (holdCnt_q == '0) begin
                            if (newp1ships == '0) begin
                                state_q  <= ST_GAMEOVER;
                                p2wins_q <= 1'b1;
                            end else if (EXTRA_TURN != 0 && lastHit_q) begin
                                state_q <= ST_P2_FIRE;
                            end else begin
                                state_q <= ST_P1_FIRE;
                            end
                        end else begin
                            holdCnt_q <= holdCnt_q - HOLD_W'(1);
                        end
                    end
                    ST_GAMEOVER: begin
                        if (enterRise) begin
                            state_q   <= ST_IDLE;
                            holdCnt_q <= '0;
                            lastHit_q <= 1'b0;
                            p1wins_q  <= 1'b0;
                            p2wins_q  <= 1'b0;
                            p1Shots_q <= '0;
                            p2Shots_q <= '0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign state        = state_q;
    assign p1place      = p1place_q;
    assign p2place      = p2place_q;
    assign p1fire       = p1fire_q;
    assign p2fire       = p2fire_q;
    assign taking_turns = takingTurns_q;
    assign place_err    = placeErr_q;
    assign last_hit     = lastHit_q;
    assign p1wins       = p1wins_q;
    assign p2wins       = p2wins_q;
    assign p1_shots     = p1Shots_q;
    assign p2_shots     = p2Shots_q;

endmodule

// File: tb/tb_battle_sequencer.sv
// Bench for battle_sequencer: two instances (no extra turn / extra turn) share
// stimulus and are compared every cycle against a per-player game model.
module tb_battle_sequencer;

    localparam int GRID = 36;
    localparam int HOLD = 4;
    localparam logic [GRID-1:0] M4 = 36'h00000000F;
    localparam logic [GRID-1:0] M5 = 36'h0000001F0;
    localparam logic [GRID-1:0] NZ = 36'h800000001;

    logic            clk = 1'b0;
    logic            CPU_RESETN;
    logic            start;
    logic            enter;
    logic [GRID-1:0] p1ships;
    logic [GRID-1:0] p2ships;
    logic [GRID-1:0] newp1ships;
    logic [GRID-1:0] newp2ships;
    logic            p1hit;
    logic            p1miss;
    logic            p2hit;
    logic            p2miss;

    logic [2:0] stateO    [2];
    logic       p1placeO  [2];
    logic       p2placeO  [2];
    logic       p1fireO   [2];
    logic       p2fireO   [2];
    logic       turnsO    [2];
    logic       placeErrO [2];
    logic       lastHitO  [2];
    logic       p1winsO   [2];
    logic       p2winsO   [2];
    logic [7:0] p1ShotsO  [2];
    logic [7:0] p2ShotsO  [2];

    always #5 clk = ~clk;

    battle_sequencer #(.GRID_CELLS(GRID), .NUM_SHIPS(5), .HOLD_CYCLES(HOLD), .EXTRA_TURN(0)) dut0 (
        .clk(clk), .CPU_RESETN(CPU_RESETN), .start(start), .enter(enter),
        .p1ships(p1ships), .p2ships(p2ships), .newp1ships(newp1ships), .newp2ships(newp2ships),
        .p1hit(p1hit), .p1miss(p1miss), .p2hit(p2hit), .p2miss(p2miss),
        .state(stateO[0]), .p1place(p1placeO[0]), .p2place(p2placeO[0]),
        .p1fire(p1fireO[0]), .p2fire(p2fireO[0]), .taking_turns(turnsO[0]),
        .place_err(placeErrO[0]), .last_hit(lastHitO[0]), .p1wins(p1winsO[0]),
        .p2wins(p2winsO[0]), .p1_shots(p1ShotsO[0]), .p2_shots(p2ShotsO[0])
    );

    battle_sequencer #(.GRID_CELLS(GRID), .NUM_SHIPS(5), .HOLD_CYCLES(HOLD), .EXTRA_TURN(1)) dut1 (
        .clk(clk), .CPU_RESETN(CPU_RESETN), .start(start), .enter(enter),
        .p1ships(p1ships), .p2ships(p2ships), .newp1ships(newp1ships), .newp2ships(newp2ships),
        .p1hit(p1hit), .p1miss(p1miss), .p2hit(p2hit), .p2miss(p2miss),
        .state(stateO[1]), .p1place(p1placeO[1]), .p2place(p2placeO[1]),
        .p1fire(p1fireO[1]), .p2fire(p2fireO[1]), .taking_turns(turnsO[1]),
        .place_err(placeErrO[1]), .last_hit(lastHitO[1]), .p1wins(p1winsO[1]),
        .p2wins(p2winsO[1]), .p1_shots(p1ShotsO[1]), .p2_shots(p2ShotsO[1])
    );

    // Game model: phase numbers follow the published state codes, and the
    // result hold is tracked as elapsed cycles rather than a countdown.
    typedef struct {
        int phase;
        int elapsed;
        bit enterPrev;
        bit lastHit;
        bit p1w;
        bit p2w;
        int s1;
        int s2;
        bit err;
        bit p1pl;
        bit p2pl;
        bit p1f;
        bit p2f;
        bit tt;
    } model_t;

    model_t mdl [2];

    typedef struct {
        bit       st;
        bit       en;
        bit [3:0] pulses;
        bit       p1Short;
        bit       n1Zero;
        int       expState;
        bit       expErr;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic modelReset();
        for (int k = 0; k < 2; k++) mdl[k] = '{default: 0};
    endtask

    task automatic clearGame(inout model_t m);
        m.phase   = 0;
        m.elapsed = 0;
        m.lastHit = 0;
        m.p1w     = 0;
        m.p2w     = 0;
        m.s1      = 0;
        m.s2      = 0;
    endtask

    task automatic modelStep();
        for (int k = 0; k < 2; k++) begin
            model_t m;
            bit     rise;
            m           = mdl[k];
            rise        = enter && !m.enterPrev;
            m.enterPrev = enter;
            m.p1pl      = (m.phase == 1);
            m.p2pl      = (m.phase == 2);
            m.p1f       = (m.phase == 3);
            m.p2f       = (m.phase == 5);
            m.tt        = (m.phase >= 3 && m.phase <= 6);
            m.err       = 0;
            if (m.phase != 0 && !start) begin
                clearGame(m);
            end else begin
                case (m.phase)
                    0: if (start && rise) m.phase = 1;
                    1: if (rise) begin
                           if ($countones(p1ships) == 5) m.phase = 2;
                           else                          m.err = 1;
                       end
                    2: if (rise) begin
                           if ($countones(p2ships) == 5) m.phase = 3;
                           else                          m.err = 1;
                       end
                    3: if (p1hit || p1miss) begin
                           m.phase   = 4;
                           m.lastHit = p1hit;
                           m.s1      = (m.s1 < 255) ? m.s1 + 1 : 255;
                           m.elapsed = 0;
                       end
                    4: begin
                           m.elapsed++;
                           if (m.elapsed == HOLD) begin
                               if (newp2ships == 0) begin
                                   m.phase = 7;
                                   m.p1w   = 1;
                               end else if (k == 1 && m.lastHit) m.phase = 3;
                               else m.phase = 5;
                           end
                       end
                    5: if (p2hit || p2miss) begin
                           m.phase   = 6;
                           m.lastHit = p2hit;
                           m.s2      = (m.s2 < 255) ? m.s2 + 1 : 255;
                           m.elapsed = 0;
                       end
                    6: begin
                           m.elapsed++;
                           if (m.elapsed == HOLD) begin
                               if (newp1ships == 0) begin
                                   m.phase = 7;
                                   m.p2w   = 1;
                               end else if (k == 1 && m.lastHit) m.phase = 5;
                               else m.phase = 3;
                           end
                       end
                    7: if (rise) clearGame(m);
                    default: m.phase = 0;
                endcase
            end
            mdl[k] = m;
        end
    endtask

    task automatic expectVal(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d got %0d expected %0d", name, k, got, exp);
        end
    endtask

    task automatic checkOutput();
        for (int k = 0; k < 2; k++) begin
            expectVal("state",        k, 32'(stateO[k]),    mdl[k].phase);
            expectVal("p1place",      k, 32'(p1placeO[k]),  32'(mdl[k].p1pl));
            expectVal("p2place",      k, 32'(p2placeO[k]),  32'(mdl[k].p2pl));
            expectVal("p1fire",       k, 32'(p1fireO[k]),   32'(mdl[k].p1f));
            expectVal("p2fire",       k, 32'(p2fireO[k]),   32'(mdl[k].p2f));
            expectVal("taking_turns", k, 32'(turnsO[k]),    32'(mdl[k].tt));
            expectVal("place_err",    k, 32'(placeErrO[k]), 32'(mdl[k].err));
            expectVal("last_hit",     k, 32'(lastHitO[k]),  32'(mdl[k].lastHit));
            expectVal("p1wins",       k, 32'(p1winsO[k]),   32'(mdl[k].p1w));
            expectVal("p2wins",       k, 32'(p2winsO[k]),   32'(mdl[k].p2w));
            expectVal("p1_shots",     k, 32'(p1ShotsO[k]),  mdl[k].s1);
            expectVal("p2_shots",     k, 32'(p2ShotsO[k]),  mdl[k].s2);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput();
    endtask

    // pulses packs {p1hit, p1miss, p2hit, p2miss}; they last one cycle.
    task automatic applyStimulus(input bit st, input bit en, input bit [3:0] pulses);
        start = st;
        enter = en;
        {p1hit, p1miss, p2hit, p2miss} = pulses;
        stepCycle();
        {p1hit, p1miss, p2hit, p2miss} = 4'b0000;
    endtask

    task automatic goPlaced();
        p1ships = M5;
        p2ships = M5;
        applyStimulus(1, 1, 4'b0000);
        applyStimulus(1, 0, 4'b0000);
        applyStimulus(1, 1, 4'b0000);
        applyStimulus(1, 0, 4'b0000);
        applyStimulus(1, 1, 4'b0000);
        applyStimulus(1, 0, 4'b0000);
    endtask

    function automatic logic [GRID-1:0] randMask(input int n);
        logic [GRID-1:0] m;
        m = '0;
        while ($countones(m) < n) m[$urandom_range(0, GRID - 1)] = 1'b1;
        return m;
    endfunction

    initial begin
        bit en;
        int cnt;

        CPU_RESETN = 1'b0;
        start      = 1'b0;
        enter      = 1'b0;
        p1ships    = '0;
        p2ships    = '0;
        newp1ships = NZ;
        newp2ships = NZ;
        {p1hit, p1miss, p2hit, p2miss} = 4'b0000;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput();
        CPU_RESETN = 1'b1;

        // st en pulses short n1Zero expState expErr  (expectations for dut0)
        vecs.push_back('{1, 0, 4'b0000, 1, 0, 0, 0});
        vecs.push_back('{1, 1, 4'b0000, 1, 0, 1, 0});
        vecs.push_back('{1, 1, 4'b0000, 1, 0, 1, 0});
        vecs.push_back('{1, 0, 4'b0000, 1, 0, 1, 0});
        vecs.push_back('{1, 1, 4'b0000, 1, 0, 1, 1});
        vecs.push_back('{1, 0, 4'b0000, 1, 0, 1, 0});
        vecs.push_back('{1, 1, 4'b0000, 0, 0, 2, 0});
        vecs.push_back('{1, 0, 4'b0000, 0, 0, 2, 0});
        vecs.push_back('{1, 1, 4'b0000, 0, 0, 3, 0});
        vecs.push_back('{1, 0, 4'b0000, 0, 0, 3, 0});
        vecs.push_back('{1, 1, 4'b0000, 0, 0, 3, 0});
        vecs.push_back('{1, 0, 4'b0010, 0, 0, 3, 0});
        vecs.push_back('{1, 0, 4'b0100, 0, 0, 4, 0});
        vecs.push_back('{1, 0, 4'b0000, 0, 0, 4, 0});
        vecs.push_back('{1, 0, 4'b1000, 0, 0, 4, 0});
        vecs.push_back('{1, 0, 4'b0000, 0, 0, 4, 0});
        vecs.push_back('{1, 0, 4'b0000, 0, 0, 5, 0});
        vecs.push_back('{1, 0, 4'b0100, 0, 0, 5, 0});
        vecs.push_back('{1, 0, 4'b0010, 0, 1, 6, 0});
        vecs.push_back('{1, 0, 4'b0000, 0, 1, 6, 0});
        vecs.push_back('{1, 0, 4'b0000, 0, 1, 6, 0});
        vecs.push_back('{1, 0, 4'b0000, 0, 1, 6, 0});
        vecs.push_back('{1, 0, 4'b0000, 0, 1, 7, 0});
        vecs.push_back('{1, 0, 4'b0000, 0, 1, 7, 0});
        vecs.push_back('{1, 1, 4'b0000, 0, 1, 0, 0});
        vecs.push_back('{1, 0, 4'b0000, 0, 0, 0, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            p1ships    = vecs[i].p1Short ? M4 : M5;
            p2ships    = M5;
            newp1ships = vecs[i].n1Zero ? '0 : NZ;
            newp2ships = NZ;
            applyStimulus(vecs[i].st, vecs[i].en, vecs[i].pulses);
            expectVal("tblState", 0, 32'(stateO[0]), vecs[i].expState);
            expectVal("tblErr",   0, 32'(placeErrO[0]), 32'(vecs[i].expErr));
        end

        // Simultaneous hit+miss counts once as a hit; extra turn diverges dut1.
        goPlaced();
        applyStimulus(1, 0, 4'b1100);
        for (int k = 0; k < 2; k++) begin
            expectVal("dualLastHit", k, 32'(lastHitO[k]), 1);
            expectVal("dualShots",   k, 32'(p1ShotsO[k]), 1);
        end
        repeat (HOLD) applyStimulus(1, 0, 4'b0000);
        expectVal("noExtraTurn", 0, 32'(stateO[0]), 5);
        expectVal("extraTurn",   1, 32'(stateO[1]), 3);
        applyStimulus(1, 0, 4'b0001);
        expectVal("p2Result", 0, 32'(stateO[0]), 6);
        applyStimulus(0, 0, 4'b0000);
        expectVal("startFall", 0, 32'(stateO[0]), 0);
        expectVal("startFall", 1, 32'(stateO[1]), 0);

        // Asynchronous reset taken in P2_FIRE, observed before the next edge.
        goPlaced();
        applyStimulus(1, 0, 4'b0100);
        repeat (HOLD + 2) applyStimulus(1, 0, 4'b0000);
        expectVal("preResetP2fire", 0, 32'(p2fireO[0]), 1);
        #2 CPU_RESETN = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            expectVal("asyncState",  k, 32'(stateO[k]),   0);
            expectVal("asyncP2fire", k, 32'(p2fireO[k]),  0);
            expectVal("asyncShots",  k, 32'(p1ShotsO[k]), 0);
            expectVal("asyncTurns",  k, 32'(turnsO[k]),   0);
        end
        modelReset();
        enter = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        CPU_RESETN = 1'b1;
        checkOutput();

        // Randomized play against the model.
        for (int c = 0; c < 3000; c++) begin
            cnt        = ($urandom_range(0, 2) == 0) ? int'($urandom_range(3, 7)) : 5;
            p1ships    = randMask(cnt);
            cnt        = ($urandom_range(0, 2) == 0) ? int'($urandom_range(3, 7)) : 5;
            p2ships    = randMask(cnt);
            newp1ships = ($urandom_range(0, 7) == 0) ? '0 : randMask(int'($urandom_range(1, 20)));
            newp2ships = ($urandom_range(0, 7) == 0) ? '0 : randMask(int'($urandom_range(1, 20)));
            en = enter;
            if ($urandom_range(0, 2) == 0) en = !en;
            applyStimulus($urandom_range(0, 149) != 0, en,
                          {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0});
        end

        // Long game of misses to drive both shot counters into saturation.
        newp1ships = NZ;
        newp2ships = NZ;
        applyStimulus(0, 0, 4'b0000);
        goPlaced();
        for (int r = 0; r < 260; r++) begin
            applyStimulus(1, 0, 4'b0100);
            repeat (HOLD) applyStimulus(1, 0, 4'b0000);
            applyStimulus(1, 0, 4'b0001);
            repeat (HOLD) applyStimulus(1, 0, 4'b0000);
        end
        for (int k = 0; k < 2; k++) begin
            expectVal("satP1", k, 32'(p1ShotsO[k]), 255);
            expectVal("satP2", k, 32'(p2ShotsO[k]), 255);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/battle_sequencer.md
Name: battle_sequencer

Overview:
- Central game-phase controller for Keyboard Battleship.
- Takes the debounced Enter level, the start flag and hit/miss results, and sequences placement, alternating fire turns, result hold and game-over.
- Drives the place/fire enables consumed by set_ships and hit_or_miss, the state code consumed by the displays, and the winner flags.
- Replaces the separate state, place-enable, fire-enable and winner logic with one registered FSM.

Parameters:
- GRID_CELLS, 36, width of the ship-mask buses (6x6 board, one bit per cell).
- NUM_SHIPS, 5, number of set bits a placement mask needs before Enter is accepted.
- HOLD_CYCLES, 100000000, clk cycles the RESULT states hold before advancing (1 s at 100 MHz); minimum 1.
- EXTRA_TURN, 0, when 1 a hit grants the same player another shot.

Ports:
- clk  input  1  system clock.
- CPU_RESETN  input  1  asynchronous active-low reset.
- start  input  1  level; high once the start screen is passed.
- enter  input  1  debounced Enter level; rising edge detected internally.
- p1ships  input  GRID_CELLS  player-1 placement mask.
- p2ships  input  GRID_CELLS  player-2 placement mask.
- newp1ships  input  GRID_CELLS  player-1 surviving ship cells.
- newp2ships  input  GRID_CELLS  player-2 surviving ship cells.
- p1hit, p1miss, p2hit, p2miss  input  1 each  shot result pulses from hit_or_miss.
- state  output  3  current phase code.
- p1place, p2place  output  1 each  placement enables.
- p1fire, p2fire  output  1 each  fire enables.
- taking_turns  output  1  high in any FIRE or RESULT state.
- place_err  output  1  one-cycle pulse on a rejected placement.
- last_hit  output  1  result of the most recent shot.
- p1wins, p2wins  output  1 each  winner flags.
- p1_shots, p2_shots  output  8 each  shot counters, saturating at 255.

Behaviour:
- State codes: IDLE=0, P1_PLACE=1, P2_PLACE=2, P1_FIRE=3, P1_RESULT=4, P2_FIRE=5, P2_RESULT=6, GAMEOVER=7.
- All outputs are registered; combinational outputs are not permitted.
- Reset: while CPU_RESETN=0, state=IDLE and every output is 0, including counters, hold timer and the enter edge register. Reset applies immediately from any state.
- enter_rise = enter & ~enter_q, where enter_q is a registered copy of enter. Only one FSM action is taken per rise.
- Moore enables: p1place=1 only in P1_PLACE; p2place=1 only in P2_PLACE; p1fire=1 only in P1_FIRE; p2fire=1 only in P2_FIRE. Enables change in the cycle after the state register updates.
- IDLE -> P1_PLACE on start=1 AND enter_rise.
- P1_PLACE on enter_rise:
  - If popcount(p1ships)==NUM_SHIPS, go to P2_PLACE.
  - Otherwise stay and pulse place_err for exactly 1 cycle.
- P2_PLACE: same rule using p2ships; success goes to P1_FIRE.
- P1_FIRE: wait for p1hit or p1miss.
  - On either, go to P1_RESULT, set last_hit=p1hit, and increment p1_shots (saturating).
  - p1hit and p1miss in the same cycle count as a hit.
  - p2hit/p2miss are ignored in P1_FIRE.
  - enter_rise has no effect in P1_FIRE.
- P1_RESULT: the hold counter loads HOLD_CYCLES-1 on entry and decrements. When it reaches 0:
  - If newp2ships==0, go to GAMEOVER and set p1wins=1.
  - Else if EXTRA_TURN=1 and last_hit=1, go to P1_FIRE.
  - Else go to P2_FIRE.
  - Shot pulses arriving during RESULT are ignored.
- P2_FIRE / P2_RESULT: mirror image, using p2hit/p2miss, p2_shots and newp1ships. A player-2 win sets p2wins=1.
- GAMEOVER:
  - Winner flags hold.
  - An enter_rise returns to IDLE and clears the winner flags, counters and last_hit.
  - p1wins and p2wins are never both 1.
- start falling to 0 in any state other than IDLE forces IDLE next cycle, clearing the same state that GAMEOVER clears. This check has priority over all other transitions.
- taking_turns = state in {3,4,5,6}.
- Hold counter width is clog2(HOLD_CYCLES)+1.

Decomposition:
- battle_pkg holds:
  - the 3-bit state encodings;
  - the GRID_CELLS default;
  - a clog2 constant function.
- One sub-module: ship_popcount, a combinational GRID_CELLS-bit population count with a clog2(GRID_CELLS+1)-bit result. It is instantiated twice, once per placement mask.
- The edge detector and hold counter stay inline.

Test Plan:
- Reset mid-P2_FIRE: deassert CPU_RESETN -> state=0, all enables 0, p1_shots=0 asynchronously, before the next clk edge.
- Placement reject: start=1, rise to P1_PLACE, p1ships with 4 bits set, enter rise -> state stays 1 and place_err is high for exactly 1 cycle. Then 5 bits set plus enter rise -> state=2, p2place=1.
- Turn alternation with HOLD_CYCLES=4, EXTRA_TURN=0: in P1_FIRE pulse p1miss -> state=4 for 4 cycles, then state=5, p2fire=1, p1_shots=1, last_hit=0.
- Extra turn with EXTRA_TURN=1: pulse p1hit, newp2ships nonzero -> after the hold, state returns to 3.
- Win: pulse p2hit with newp1ships=0 -> after the hold, state=7, p2wins=1, p1wins=0. Enter rise -> state=0, p2wins=0.
- Simultaneous and stray events: p1hit&p1miss in the same cycle -> last_hit=1 and a single count. p2hit during P1_FIRE -> no change. A held enter level -> only one transition. start falls while in state 6 -> state=0.
